instruction_sequencer: RTL
==========================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high; it takes effect on the clock edge where it is sampled high.
REQ-004 imem_req_valid  output  1  SHALL signal a fetch request.
REQ-005 imem_req_ready  input  1  SHALL signal that memory accepts the request.
REQ-006 imem_addr  output  32  SHALL carry the fetch address; it equals pc.
REQ-007 imem_rsp_valid  input  1  SHALL qualify imem_rsp_data.
REQ-008 imem_rsp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 instruction  output  32  SHALL be the instruction register driving the decoder.
REQ-010 opcode  input  7  SHALL be the decoder's opcode field for instruction.
REQ-011 exec_start  output  1  SHALL be a one-cycle pulse starting execution.
REQ-012 exec_done  input  1  SHALL signal that the execute unit has finished.
REQ-013 branch_taken  input  1  SHALL be the branch resolution, sampled with exec_done.
REQ-014 target_pc  input  32  SHALL be the jump/branch target, sampled with exec_done.
REQ-015 pc  output  32  SHALL be the architectural program counter.
REQ-016 rd_write_enable  output  1  SHALL be a one-cycle register-file write strobe.
REQ-017 halted  output  1  SHALL indicate the HALT state.
REQ-018 instret  output  32  SHALL count retired instructions.

Function
REQ-019 States SHALL be FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-020 FETCH_REQ: imem_req_valid=1; on imem_req_ready=1, go to FETCH_WAIT; otherwise stay, holding imem_addr stable.
REQ-021 FETCH_WAIT: imem_req_valid=0; on imem_rsp_valid=1, load instruction from imem_rsp_data and go to DECODE.
REQ-022 DECODE: one cycle; legal opcodes are 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011; a legal opcode goes to EXECUTE with exec_start=1 in the first EXECUTE cycle only; any other opcode goes to HALT.
REQ-023 EXECUTE: wait for exec_done=1; if exec_done arrives in the exec_start cycle, accept it; capture branch_taken and target_pc, then go to WRITEBACK.
REQ-024 Next PC SHALL be target_pc for opcodes 1101111 and 1100111; for 1100011 it is target_pc when branch_taken=1; all other cases use pc+4, wrapping modulo 2^32.
REQ-025 For 1100111, bit 0 of target_pc SHALL be cleared before use.
REQ-026 A selected next PC with bits[1:0]!=0 SHALL go to HALT; pc and instret stay unchanged and rd_write_enable=0.
REQ-027 WRITEBACK: rd_write_enable=1 for one cycle, except opcodes 1100011, 0100011, 0001111 and 1110011, which use 0; pc updates to next PC, instret increments by 1 (wrapping 32'hFFFFFFFF to 0), then go to FETCH_REQ.
REQ-028 HALT SHALL be absorbing until reset: halted=1, all strobes 0, pc/instret frozen.
REQ-029 imem_rsp_valid outside FETCH_WAIT and exec_done outside EXECUTE SHALL be ignored.
REQ-030 Latency, ready/valid asserted immediately: FETCH_REQ to next FETCH_REQ = 5 cycles (REQ, WAIT, DECODE, EXECUTE, WRITEBACK).

Reset
REQ-031 On reset: state=FETCH_REQ, pc=RESET_VECTOR, instruction=32'h00000013, instret=0, rd_write_enable=0, exec_start=0, halted=0, and imem_req_valid=1 in the first cycle after reset.
REQ-032 Reset asserted in any state, including mid-fetch or HALT, SHALL override all transitions; any in-flight response or exec_done SHALL be discarded.

Verification
REQ-033 Reset, ready=1, rsp=32'h00500093 next cycle, exec_done in exec_start cycle -> rd_write_enable pulse in cycle 5, pc=4, instret=1.
REQ-034 Branch 32'h00000463 with branch_taken=1, target_pc=32'h00000010 -> pc=32'h10, rd_write_enable=0; with branch_taken=0 -> pc=4.
REQ-035 JALR with target_pc=32'h00000021 -> pc=32'h20; JAL with target_pc=32'h00000022 -> halted=1, pc unchanged.
REQ-036 Response 32'hFFFFFFFF (opcode 1111111) -> HALT after DECODE, exec_start never pulses, instret unchanged.
REQ-037 imem_req_ready held 0 for 3 cycles, then spurious exec_done/imem_rsp_valid in FETCH_REQ -> imem_addr stable, no state change until ready.
REQ-038 Reset in EXECUTE with pc=32'h40 -> next cycle pc=RESET_VECTOR, state=FETCH_REQ; late exec_done is ignored; pc=32'hFFFFFFFC with sequential retire -> pc=0.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetch / decode / execute / writeback control with PC
// and retired-instruction tracking.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_REQ  | present pc on imem_addr, wait for imem_req_ready
// FETCH_WAIT | wait for imem_rsp_valid, latch the instruction word
// DECODE     | single cycle opcode legality check
// EXECUTE    | exec_start on first cycle, wait for exec_done, pick next pc
// WRITEBACK  | rd strobe, commit next pc, bump instret
// HALT       | absorbing until reset; everything frozen
module instruction_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instruction,
   input  logic [6:0]  opcode,
   output logic        exec_start,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] target_pc,
   output logic [31:0] pc,
   output logic        rd_write_enable,
   output logic        halted,
   output logic [31:0] instret
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FETCH_REQ  = 3'd0,
      FETCH_WAIT = 3'd1,
      DECODE     = 3'd2,
      EXECUTE    = 3'd3,
      WRITEBACK  = 3'd4,
      HALT       = 3'd5
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        op_legal;
   logic        op_no_rd;
   logic [31:0] sel_pc;
   logic [31:0] next_pc_q;

   // Opcode classification from the decoder's field.
   always_comb begin
      op_legal = 1'b0;
      op_no_rd = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: op_legal = 1'b1;
         OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM: begin
            op_legal = 1'b1;
            op_no_rd = 1'b1;
         end
         default: op_legal = 1'b0;
      endcase
   end

   // Candidate next pc from the execute unit's live resolution.
   always_comb begin
      sel_pc = pc + 32'd4;
      if (opcode == OP_JAL)
         sel_pc = target_pc;
      else if (opcode == OP_JALR)
         sel_pc = {target_pc[31:1], 1'b0};
      else if ((opcode == OP_BRANCH) && branch_taken)
         sel_pc = target_pc;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= FETCH_REQ;
      else
         state <= next_state;
   end

   // Next-state logic; a misaligned next pc halts before anything commits.
   always_comb begin
      next_state = state;
      case (state)
         FETCH_REQ:  if (imem_req_ready) next_state = FETCH_WAIT;
         FETCH_WAIT: if (imem_rsp_valid) next_state = DECODE;
         DECODE:     next_state = op_legal ? EXECUTE : HALT;
         EXECUTE:    if (exec_done) next_state = (sel_pc[1:0] != 2'b00) ? HALT : WRITEBACK;
         WRITEBACK:  next_state = FETCH_REQ;
         HALT:       next_state = HALT;
         default:    next_state = HALT;
      endcase
   end

   // Output decode from the current state.
   always_comb begin
      imem_req_valid  = (state == FETCH_REQ);
      halted          = (state == HALT);
      rd_write_enable = (state == WRITEBACK) && !op_no_rd;
   end

   assign imem_addr = pc;

   // Datapath registers: instruction latch, resolved pc, commit, start pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc          <= RESET_VECTOR;
         instruction <= 32'h0000_0013;
         instret     <= 32'd0;
         exec_start  <= 1'b0;
         next_pc_q   <= 32'd0;
      end else begin
         exec_start <= (state == DECODE) && op_legal;
         if ((state == FETCH_WAIT) && imem_rsp_valid)
            instruction <= imem_rsp_data;
         if ((state == EXECUTE) && exec_done)
            next_pc_q <= sel_pc;
         if (state == WRITEBACK) begin
            pc      <= next_pc_q;
            instret <= instret + 32'd1;
         end
      end
   end

endmodule
